// File: rtl/pipeline_types_pkg.sv
// Shared pipeline types for the memory access stage: access widths, FSM states,
// byte-enable patterns and alignment helpers.
package pipeline_types_pkg;

  typedef enum logic [1:0] {
    MemByte    = 2'd0,
    MemHalf    = 2'd1,
    MemWord    = 2'd2,
    MemWordAlt = 2'd3
  } mem_access_width_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } mem_stage_state_e;

  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  // Encoding 3 behaves exactly like a word access.
  function automatic mem_access_width_e norm_width(input logic [1:0] width);
    return (width == 2'd3) ? MemWord : mem_access_width_e'(width);
  endfunction

  function automatic logic is_misaligned(input mem_access_width_e width,
                                         input logic [1:0] offset);
    case (width)
      MemByte: return 1'b0;
      MemHalf: return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Selects the addressed byte/half lane of a load word and sign- or zero-extends it.
module load_aligner
  import pipeline_types_pkg::*;
(
  input  logic [31:0]       rdata,
  input  logic [1:0]        offset,
  input  mem_access_width_e width,
  input  logic              is_unsigned,
  output logic [31:0]       data
);

  logic [15:0] lane;

  always_comb begin
    lane = 16'(rdata >> {offset, 3'b000});
    case (width)
      MemByte: data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
      MemHalf: data = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline memory stage: issues aligned data-memory requests, waits for ack with a
// timeout, and produces a registered writeback result with error pulses.
module memory_access_stage
  import pipeline_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_width,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic        in_is_load_unsigned,
  input  logic        in_rd_we,
  input  logic [4:0]  in_rd_addr,
  output logic        stall_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_rd_we,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_addr,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  mem_stage_state_e  state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;

  // Operation latched at request time; upstream may hold or change its inputs afterwards.
  mem_access_width_e op_width_q, op_width_d;
  logic [1:0]        op_offset_q, op_offset_d;
  logic              op_unsigned_q, op_unsigned_d;
  logic              op_store_q, op_store_d;
  logic              op_rd_we_q, op_rd_we_d;
  logic [4:0]        op_rd_addr_q, op_rd_addr_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_rd_we_q, wb_rd_we_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_addr_q, wb_rd_addr_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;

  mem_access_width_e in_width_n;
  logic [1:0]        in_offset;
  logic              in_is_mem;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic [31:0]       load_data;

  load_aligner u_load_aligner (
    .rdata       (dmem_rdata),
    .offset      (op_offset_q),
    .width       (op_width_q),
    .is_unsigned (op_unsigned_q),
    .data        (load_data)
  );

  always_comb begin
    in_width_n = norm_width(in_width);
    in_offset  = in_alu_result[1:0];
    in_is_mem  = in_is_load | in_is_store;
    case (in_width_n)
      MemByte: begin
        be_calc    = BeByte << in_offset;
        wdata_calc = {4{in_wdata[7:0]}};
      end
      MemHalf: begin
        be_calc    = BeHalf << in_offset;
        wdata_calc = {2{in_wdata[15:0]}};
      end
      default: begin
        be_calc    = BeWord;
        wdata_calc = in_wdata;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    op_width_d    = op_width_q;
    op_offset_d   = op_offset_q;
    op_unsigned_d = op_unsigned_q;
    op_store_d    = op_store_q;
    op_rd_we_d    = op_rd_we_q;
    op_rd_addr_d  = op_rd_addr_q;
    wb_valid_d    = 1'b0;
    wb_rd_we_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_rd_addr_d  = wb_rd_addr_q;
    mis_d         = 1'b0;
    berr_d        = 1'b0;
    stall_req     = 1'b0;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!in_is_mem) begin
            wb_valid_d   = 1'b1;
            wb_rd_we_d   = in_rd_we;
            wb_data_d    = in_alu_result;
            wb_rd_addr_d = in_rd_addr;
          end else if (is_misaligned(in_width_n, in_offset)) begin
            wb_valid_d   = 1'b1;
            mis_d        = 1'b1;
            wb_rd_addr_d = in_rd_addr;
          end else begin
            stall_req     = 1'b1;
            state_d       = StAccess;
            cnt_d         = '0;
            req_d         = 1'b1;
            we_d          = in_is_store;
            addr_d        = {in_alu_result[31:2], 2'b00};
            be_d          = be_calc;
            wdata_d       = wdata_calc;
            op_width_d    = in_width_n;
            op_offset_d   = in_offset;
            op_unsigned_d = in_is_load_unsigned;
            op_store_d    = in_is_store;
            op_rd_we_d    = in_rd_we;
            op_rd_addr_d  = in_rd_addr;
          end
        end
      end
      StAccess: begin
        stall_req = ~dmem_ack;
        if (dmem_ack) begin
          state_d      = StIdle;
          cnt_d        = '0;
          req_d        = 1'b0;
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = op_rd_addr_q;
          if (!op_store_q) begin
            wb_rd_we_d = op_rd_we_q;
            wb_data_d  = load_data;
          end
        end else if (cnt_q == CntLast) begin
          state_d      = StIdle;
          cnt_d        = '0;
          req_d        = 1'b0;
          berr_d       = 1'b1;
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = op_rd_addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      op_width_q    <= MemByte;
      op_offset_q   <= '0;
      op_unsigned_q <= 1'b0;
      op_store_q    <= 1'b0;
      op_rd_we_q    <= 1'b0;
      op_rd_addr_q  <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_we_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_addr_q  <= '0;
      mis_q         <= 1'b0;
      berr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      op_width_q    <= op_width_d;
      op_offset_q   <= op_offset_d;
      op_unsigned_q <= op_unsigned_d;
      op_store_q    <= op_store_d;
      op_rd_we_q    <= op_rd_we_d;
      op_rd_addr_q  <= op_rd_addr_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_we_q    <= wb_rd_we_d;
      wb_data_q     <= wb_data_d;
      wb_rd_addr_q  <= wb_rd_addr_d;
      mis_q         <= mis_d;
      berr_q        <= berr_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd_we     = wb_rd_we_q;
  assign wb_data      = wb_data_q;
  assign wb_rd_addr   = wb_rd_addr_q;
  assign misalign_err = mis_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: per-operation expectations from arithmetic
// rules, checked every cycle, plus literal pins on the worked examples.
module tb_memory_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_wdata = '0;
  logic [1:0]  in_width = '0;
  logic        in_is_load = 1'b0;
  logic        in_is_store = 1'b0;
  logic        in_is_load_unsigned = 1'b0;
  logic        in_rd_we = 1'b0;
  logic [4:0]  in_rd_addr = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  logic        stall_req, dmem_req, dmem_we, wb_valid, wb_rd_we, misalign_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd_addr;

  memory_access_stage #(.TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_alu_result       (in_alu_result),
    .in_wdata            (in_wdata),
    .in_width            (in_width),
    .in_is_load          (in_is_load),
    .in_is_store         (in_is_store),
    .in_is_load_unsigned (in_is_load_unsigned),
    .in_rd_we            (in_rd_we),
    .in_rd_addr          (in_rd_addr),
    .stall_req           (stall_req),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_be             (dmem_be),
    .dmem_wdata          (dmem_wdata),
    .dmem_ack            (dmem_ack),
    .dmem_rdata          (dmem_rdata),
    .wb_valid            (wb_valid),
    .wb_rd_we            (wb_rd_we),
    .wb_data             (wb_data),
    .wb_rd_addr          (wb_rd_addr),
    .misalign_err        (misalign_err),
    .bus_err             (bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle.
  logic        e_stall = 0, e_req = 0, e_we = 0, e_wb_valid = 0, e_wb_we = 0;
  logic        e_mis = 0, e_berr = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_wb_data = 0;
  logic [3:0]  e_be = 0;
  logic [4:0]  e_wb_addr = 0;

  int          seen_req = 0, seen_stall = 0;
  logic [3:0]  seen_be = 0;
  logic [31:0] seen_wdata = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("stall_req", {31'b0, stall_req}, {31'b0, e_stall});
    chk("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, e_mis});
    chk("bus_err", {31'b0, bus_err}, {31'b0, e_berr});
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_wb_valid});
    chk("wb_data", wb_data, e_wb_data);
    if (e_req) begin
      chk("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_be", {28'b0, dmem_be}, {28'b0, e_be});
      if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
    end
    if (e_wb_valid) begin
      chk("wb_rd_we", {31'b0, wb_rd_we}, {31'b0, e_wb_we});
      chk("wb_rd_addr", {27'b0, wb_rd_addr}, {27'b0, e_wb_addr});
    end
    if (dmem_req) begin
      seen_req++;
      seen_be    = dmem_be;
      seen_wdata = dmem_wdata;
    end
    if (stall_req) seen_stall++;
  end

  // Advance one edge; pulse expectations fall back to 0.
  task automatic tick();
    @(posedge clk);
    #1;
    e_wb_valid = 0;
    e_wb_we    = 0;
    e_mis      = 0;
    e_berr     = 0;
  endtask

  function automatic logic [31:0] ext_load(input logic [31:0] rd, input int w, input int a,
                                           input logic uns);
    logic [31:0] v;
    v = rd >> (8 * a);
    if (w == 0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (w == 1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic alu_op(input logic [31:0] val, input logic [4:0] rd, input logic we);
    in_valid = 1; in_is_load = 0; in_is_store = 0;
    in_alu_result = val; in_rd_addr = rd; in_rd_we = we;
    e_stall = 0;
    tick();
    e_wb_valid = 1; e_wb_we = we; e_wb_addr = rd; e_wb_data = val;
    in_valid = 0;
  endtask

  // ack_after: number of ACCESS cycles without ack before ack; negative means never.
  task automatic mem_op(input logic [1:0] w, input logic [31:0] addr, input logic [31:0] wd,
                        input logic ld, input logic st, input logic uns, input logic [4:0] rd,
                        input logic we, input int ack_after, input logic [31:0] rdata);
    int wm, a;
    logic mis;
    wm = (w == 2'd3) ? 2 : int'(w);
    a  = int'(addr[1:0]);
    mis = (wm == 1 && a % 2 == 1) || (wm == 2 && a != 0);
    seen_req = 0; seen_stall = 0;
    in_valid = 1; in_width = w; in_alu_result = addr; in_wdata = wd;
    in_is_load = ld; in_is_store = st; in_is_load_unsigned = uns;
    in_rd_addr = rd; in_rd_we = we;
    if (mis) begin
      e_stall = 0;
      tick();
      e_wb_valid = 1; e_mis = 1; e_wb_we = 0; e_wb_addr = rd;
    end else begin
      e_stall = 1;
      tick();
      e_req  = 1;
      e_we   = st;
      e_addr = addr & 32'hFFFF_FFFC;
      e_be   = (wm == 0) ? 4'(1 << a) : (wm == 1) ? 4'(3 << a) : 4'hF;
      e_wdata = (wm == 0) ? {4{wd[7:0]}} : (wm == 1) ? {2{wd[15:0]}} : wd;
      for (int n = 0; n < int'(TO); n++) begin
        if (n == ack_after) begin
          dmem_ack = 1; dmem_rdata = rdata; e_stall = 0;
          tick();
          dmem_ack = 0; e_req = 0;
          e_wb_valid = 1; e_wb_addr = rd;
          e_wb_we = st ? 1'b0 : we;
          if (!st) e_wb_data = ext_load(rdata, wm, a, uns);
          break;
        end else if (n == int'(TO) - 1) begin
          e_stall = 1;
          tick();
          e_req = 0; e_berr = 1; e_wb_valid = 1; e_wb_we = 0; e_wb_addr = rd;
        end else begin
          e_stall = 1;
          tick();
        end
      end
    end
    in_valid = 0;
    e_stall = 0;
  endtask

  initial begin
    #2;
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    alu_op(32'h1111_1111, 5'd1, 1);
    alu_op(32'hDEAD_BEEF, 5'd2, 1);
    alu_op(32'h0000_0000, 5'd3, 0);
    chk("b2b_seen_stall", seen_stall, 0);
    tick();

    // lb 0x103, ack after two waiting cycles.
    mem_op(2'd0, 32'h103, 32'h0, 1, 0, 0, 5'd5, 1, 2, 32'h80FF_1234);
    chk("lb_be", {28'b0, seen_be}, 32'h8);
    chk("lb_stall_cycles", seen_stall, 3);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    tick();

    mem_op(2'd1, 32'h102, 32'h0, 1, 0, 1, 5'd6, 1, 0, 32'hBEEF_0000);
    chk("lhu_be", {28'b0, seen_be}, 32'hC);
    chk("lhu_wb_data", wb_data, 32'h0000_BEEF);
    tick();

    mem_op(2'd1, 32'h102, 32'h1234, 0, 1, 0, 5'd7, 1, 1, 32'h0);
    chk("sh_wdata", seen_wdata, 32'h1234_1234);
    chk("sh_be", {28'b0, seen_be}, 32'hC);
    chk("sh_wb_rd_we", {31'b0, wb_rd_we}, 32'd0);
    tick();

    mem_op(2'd2, 32'h101, 32'h0, 1, 0, 0, 5'd8, 1, 0, 32'h0);
    chk("lw_mis_err", {31'b0, misalign_err}, 32'd1);
    chk("lw_mis_rd_we", {31'b0, wb_rd_we}, 32'd0);
    chk("lw_mis_req", seen_req, 0);
    chk("lw_mis_stall", seen_stall, 0);
    tick();

    mem_op(2'd1, 32'h101, 32'h0, 1, 0, 0, 5'd9, 1, 0, 32'h0);
    tick();

    mem_op(2'd2, 32'h200, 32'h5555_AAAA, 0, 1, 0, 5'd10, 0, -1, 32'h0);
    chk("sw_to_req_cycles", seen_req, 4);
    chk("sw_to_bus_err", {31'b0, bus_err}, 32'd1);
    tick();

    // Ack on the last allowed cycle beats the timeout; width 3 acts as word.
    mem_op(2'd3, 32'h204, 32'h0, 1, 0, 0, 5'd11, 1, int'(TO) - 1, 32'hCAFE_F00D);
    chk("lw_late_ack_data", wb_data, 32'hCAFE_F00D);
    chk("lw_late_ack_no_berr", {31'b0, bus_err}, 32'd0);
    tick();

    // Load and store flags together behave as a store.
    mem_op(2'd0, 32'h301, 32'h0000_00AB, 1, 1, 0, 5'd12, 1, 0, 32'h1234_5678);
    chk("ldst_be", {28'b0, seen_be}, 32'h2);
    chk("ldst_wdata", seen_wdata, 32'hABAB_ABAB);
    tick();

    mem_op(2'd1, 32'h100, 32'h0, 1, 0, 0, 5'd13, 1, 1, 32'h0000_8001);
    chk("lh_wb_data", wb_data, 32'hFFFF_8001);
    mem_op(2'd0, 32'h102, 32'h0, 1, 0, 1, 5'd14, 1, 0, 32'h0080_0000);
    chk("lbu_wb_data", wb_data, 32'h0000_0080);
    tick();

    // Stray ack in IDLE must do nothing.
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    tick();

    // Reset in the middle of an access.
    in_valid = 1; in_width = 2'd2; in_alu_result = 32'h400; in_is_load = 1;
    in_is_store = 0; in_rd_addr = 5'd15; in_rd_we = 1;
    e_stall = 1;
    tick();
    e_req = 1; e_we = 0; e_addr = 32'h400; e_be = 4'hF;
    #1;
    rst = 1; in_valid = 0;
    e_stall = 0; e_req = 0; e_wb_data = 0; e_wb_addr = 0;
    #1;
    chk("rst_mid_req", {31'b0, dmem_req}, 32'd0);
    #5 rst = 0;
    tick();
    chk("rst_mid_no_wb", {31'b0, wb_valid}, 32'd0);
    alu_op(32'h0000_0042, 5'd16, 1);
    chk("post_rst_alu", wb_data, 32'h0000_0042);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage
Interface
REQ-001 Parameter TIMEOUT, default 64, max cycles ACCESS waits for dmem_ack before aborting.
REQ-002 clk  in  1  single clock, all flops on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 in_valid  in  1  execute-stage result present.
REQ-005 in_alu_result  in  32  ALU result or effective address.
REQ-006 in_wdata  in  32  store data, bypassed rs2.
REQ-007 in_width  in  2  0 byte, 1 half, 2 word, 3 treated as word.
REQ-008 in_is_load / in_is_store / in_is_load_unsigned  in  1 each  op flags.
REQ-009 in_rd_we  in  1  destination write enable.
REQ-010 in_rd_addr  in  5  destination register.
REQ-011 stall_req  out  1  freeze upstream stages, combinational.
REQ-012 dmem_req  out  1  memory request, registered, held until ack.
REQ-013 dmem_we  out  1  1 store, 0 load.
REQ-014 dmem_addr  out  32  word-aligned address, low 2 bits 0.
REQ-015 dmem_be  out  4  byte enables.
REQ-016 dmem_wdata  out  32  lane-replicated store data.
REQ-017 dmem_ack  in  1  one-cycle completion; dmem_rdata valid same cycle.
REQ-018 dmem_rdata  in  32  load word.
REQ-019 wb_valid / wb_rd_we  out  1 each  writeback valid, register write enable.
REQ-020 wb_data  out  32  writeback value; wb_rd_addr  out  5.
REQ-021 misalign_err / bus_err  out  1 each  one-cycle error pulses.
Function
REQ-022 FSM states IDLE, ACCESS. IDLE: non-memory op with in_valid -> wb_valid=1 next edge, wb_data=in_alu_result, latency 1.
REQ-023 IDLE, aligned memory op: latch op, dmem_req=1 next edge, state ACCESS. stall_req=1 this cycle.
REQ-024 ACCESS: stall_req=!dmem_ack. On dmem_ack: drop dmem_req, write WB regs, return to IDLE. Upstream advances on the same edge.
REQ-025 Alignment: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned. No request; next edge misalign_err=1, wb_valid=1, wb_rd_we=0.
REQ-026 Both in_is_load and in_is_store set: treated as store.
REQ-027 Byte enables, a=addr[1:0]: byte 0001<<a; half 0011<<a; word 1111. Store data: byte replicated x4, half replicated x2.
REQ-028 Load: select lane at a, sign-extend unless in_is_load_unsigned. wb_rd_we=in_rd_we. Stores force wb_rd_we=0.
REQ-029 ACCESS counter counts from 0. At TIMEOUT-1 without ack: abort, dmem_req=0, bus_err=1 one cycle, wb_valid=1 with wb_rd_we=0, IDLE.
REQ-030 Ack arriving on the timeout cycle wins over the abort; an ack in IDLE is ignored.
REQ-031 wb_valid, misalign_err and bus_err are one-cycle pulses. Otherwise 0; wb_data holds its last value.
Reset
REQ-032 rst asserted: state IDLE, dmem_req=0, counter=0. All wb_*, err and dmem_* regs are 0 immediately.
REQ-033 rst during ACCESS aborts the access with no WB pulse. First request is possible one edge after rst deasserts.
Structure
REQ-034 MemAccessWidth enum, MemStageState enum and byte-enable constants go in the shared PipelineTypes package.
REQ-035 One combinational sub-module load_aligner does lane select and extension; the FSM, counter and WB regs stay in the top.
Verification
REQ-036 lb addr 0x103, rdata 0x80FF1234, ack after 2 cycles -> be=1000, stall 3 cycles, wb_data=0xFFFFFF80.
REQ-037 lhu addr 0x102, rdata 0xBEEF0000 -> be=1100, wb_data=0x0000BEEF. sh wdata 0x1234 at 0x102 -> dmem_wdata=0x12341234, be=1100.
REQ-038 lw addr 0x101 -> no dmem_req, misalign_err pulse, wb_rd_we=0, stall_req=0.
REQ-039 sw, ack never, TIMEOUT=4 -> dmem_req high 4 cycles, then bus_err pulse and IDLE.
REQ-040 rst pulse mid-ACCESS -> dmem_req low immediately, no wb_valid. Back-to-back ALU ops -> wb_valid every cycle, no stall.
